// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-ported register file with a per-register busy scoreboard.
//
// Two combinational read ports, one synchronous write port, and one issue port
// that marks a destination register as busy until its result is written back.
// busy_count tracks the number of busy registers, updated incrementally so it
// always equals the population count of the busy vector.
//
// Optional feature: define REG_FILE_SB_BYPASS_EN to forward the write port to
// the read ports in the same cycle. When undefined, reads reflect stored state
// only.
module reg_file_sb #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] reg_write_dest,
    input  logic [DATA_W-1:0] reg_write_data,
    input  logic [ADDR_W-1:0] reg_read_addr_1,
    input  logic [ADDR_W-1:0] reg_read_addr_2,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_dest,
    output logic [DATA_W-1:0] reg_read_data_1,
    output logic [DATA_W-1:0] reg_read_data_2,
    output logic              busy_1,
    output logic              busy_2,
    output logic [ADDR_W:0]   busy_count
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam bit          ZeroEn = (ZERO_REG != 0);
    localparam logic [ADDR_W:0] CntOne = 1;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;

    logic wr_en;
    logic iss_en;
    logic cnt_inc;
    logic cnt_dec;

    logic [ADDR_W-1:0] raddr [2];
    logic [DATA_W-1:0] rdata [2];
    logic              rbusy [2];

    // Qualify write and issue enables; register 0 is immutable when hardwired.
    always_comb begin
        wr_en  = reg_write;
        iss_en = issue_valid;
        if (ZeroEn && (reg_write_dest == '0)) begin
            wr_en = 1'b0;
        end
        if (ZeroEn && (issue_dest == '0)) begin
            iss_en = 1'b0;
        end
    end

    // Next busy vector: writeback clears, issue sets; issue is applied last so it wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[reg_write_dest] = 1'b0;
        end
        if (iss_en) begin
            busy_d[issue_dest] = 1'b1;
        end
    end

    // Incremental popcount: only real 0->1 and 1->0 transitions move the count.
    always_comb begin
        cnt_inc = iss_en && !busy_q[issue_dest];
        cnt_dec = wr_en && busy_q[reg_write_dest] &&
                  !(iss_en && (issue_dest == reg_write_dest));
        count_d = count_q;
        unique case ({cnt_inc, cnt_dec})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    // Register data storage with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[reg_write_dest] <= reg_write_data;
        end
    end

    // Busy scoreboard and its population count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign raddr[0] = reg_read_addr_1;
    assign raddr[1] = reg_read_addr_2;

    // Combinational read ports; everything reads as zero while reset is held.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = '0;
            rbusy[p] = 1'b0;
            if (reset && !(ZeroEn && (raddr[p] == '0))) begin
                rdata[p] = regs_q[raddr[p]];
                rbusy[p] = busy_q[raddr[p]];
`ifdef REG_FILE_SB_BYPASS_EN
                // Forward the in-flight write; a same-address issue keeps it busy.
                if (wr_en && (reg_write_dest == raddr[p])) begin
                    rdata[p] = reg_write_data;
                    rbusy[p] = iss_en && (issue_dest == raddr[p]);
                end
`endif
            end
        end
    end

    assign reg_read_data_1 = rdata[0];
    assign reg_read_data_2 = rdata[1];
    assign busy_1          = rbusy[0];
    assign busy_2          = rbusy[1];
    assign busy_count      = count_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Testbench for reg_file_sb: table-driven vectors plus hand-written sequences
// for same-cycle forwarding and asynchronous reset behaviour.
module tb_reg_file_sb;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned ADDR_W = 5;

    logic              clk;
    logic              reset;
    logic              reg_write;
    logic [ADDR_W-1:0] reg_write_dest;
    logic [DATA_W-1:0] reg_write_data;
    logic [ADDR_W-1:0] reg_read_addr_1;
    logic [ADDR_W-1:0] reg_read_addr_2;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_dest;
    logic [DATA_W-1:0] reg_read_data_1;
    logic [DATA_W-1:0] reg_read_data_2;
    logic              busy_1;
    logic              busy_2;
    logic [ADDR_W:0]   busy_count;

    int checks;
    int errors;

    reg_file_sb #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .reg_write       (reg_write),
        .reg_write_dest  (reg_write_dest),
        .reg_write_data  (reg_write_data),
        .reg_read_addr_1 (reg_read_addr_1),
        .reg_read_addr_2 (reg_read_addr_2),
        .issue_valid     (issue_valid),
        .issue_dest      (issue_dest),
        .reg_read_data_1 (reg_read_data_1),
        .reg_read_data_2 (reg_read_data_2),
        .busy_1          (busy_1),
        .busy_2          (busy_2),
        .busy_count      (busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] wd;
        logic [DATA_W-1:0] wdata;
        logic              iss;
        logic [ADDR_W-1:0] id;
        logic [ADDR_W-1:0] a1;
        logic [ADDR_W-1:0] a2;
        logic [DATA_W-1:0] e1;
        logic [DATA_W-1:0] e2;
        logic              eb1;
        logic              eb2;
        logic [ADDR_W:0]   ecnt;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        reg_write      = 1'b0;
        reg_write_dest = '0;
        reg_write_data = '0;
        issue_valid    = 1'b0;
        issue_dest     = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // we, wd, wdata, iss, id, a1, a2, e1, e2, eb1, eb2, ecnt (state accumulates)
        vecs[0]  = '{1'b1, 5'd7,  64'd916,     1'b0, 5'd0,  5'd7,  5'd7,
                     64'd916, 64'd916, 1'b0, 1'b0, 6'd0};
        vecs[1]  = '{1'b0, 5'd0,  64'd0,       1'b1, 5'd3,  5'd3,  5'd4,
                     64'd0, 64'd0, 1'b1, 1'b0, 6'd1};
        vecs[2]  = '{1'b0, 5'd0,  64'd0,       1'b1, 5'd4,  5'd3,  5'd4,
                     64'd0, 64'd0, 1'b1, 1'b1, 6'd2};
        vecs[3]  = '{1'b0, 5'd0,  64'd0,       1'b1, 5'd3,  5'd3,  5'd4,
                     64'd0, 64'd0, 1'b1, 1'b1, 6'd2};
        vecs[4]  = '{1'b1, 5'd3,  64'hAAAA,    1'b0, 5'd0,  5'd3,  5'd4,
                     64'hAAAA, 64'd0, 1'b0, 1'b1, 6'd1};
        vecs[5]  = '{1'b1, 5'd9,  64'd55,      1'b1, 5'd9,  5'd9,  5'd9,
                     64'd55, 64'd55, 1'b1, 1'b1, 6'd2};
        vecs[6]  = '{1'b1, 5'd0,  64'd123,     1'b1, 5'd0,  5'd0,  5'd7,
                     64'd0, 64'd916, 1'b0, 1'b0, 6'd2};
        vecs[7]  = '{1'b1, 5'd4,  64'h44,      1'b1, 5'd10, 5'd10, 5'd4,
                     64'd0, 64'h44, 1'b1, 1'b0, 6'd2};
        vecs[8]  = '{1'b1, 5'd11, 64'h1111,    1'b0, 5'd0,  5'd11, 5'd10,
                     64'h1111, 64'd0, 1'b0, 1'b1, 6'd2};
        vecs[9]  = '{1'b1, 5'd31, {64{1'b1}},  1'b0, 5'd0,  5'd31, 5'd30,
                     {64{1'b1}}, 64'd0, 1'b0, 1'b0, 6'd2};
        vecs[10] = '{1'b1, 5'd9,  64'd77,      1'b0, 5'd0,  5'd9,  5'd10,
                     64'd77, 64'd0, 1'b0, 1'b1, 6'd1};
        vecs[11] = '{1'b1, 5'd5,  64'd17,      1'b0, 5'd0,  5'd5,  5'd5,
                     64'd17, 64'd17, 1'b0, 1'b0, 6'd1};

        // Reset held from time zero; a pending write must not land.
        reset = 1'b0;
        idle_inputs();
        reg_write       = 1'b1;
        reg_write_dest  = 5'd7;
        reg_write_data  = 64'd555;
        issue_valid     = 1'b1;
        issue_dest      = 5'd3;
        reg_read_addr_1 = 5'd7;
        reg_read_addr_2 = 5'd3;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rd1", reg_read_data_1, 64'd0);
        chk("reset_b2", {63'd0, busy_2}, 64'd0);
        chk("reset_cnt", {58'd0, busy_count}, 64'd0);
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        #1;
        chk("post_reset_rd1", reg_read_data_1, 64'd0);

        // Table-driven vectors.
        for (int i = 0; i < NVEC; i++) begin
            reg_write      = vecs[i].we;
            reg_write_dest = vecs[i].wd;
            reg_write_data = vecs[i].wdata;
            issue_valid    = vecs[i].iss;
            issue_dest     = vecs[i].id;
            @(posedge clk);
            #1;
            idle_inputs();
            reg_read_addr_1 = vecs[i].a1;
            reg_read_addr_2 = vecs[i].a2;
            #1;
            chk($sformatf("v%0d_rd1", i), reg_read_data_1, vecs[i].e1);
            chk($sformatf("v%0d_rd2", i), reg_read_data_2, vecs[i].e2);
            chk($sformatf("v%0d_b1", i), {63'd0, busy_1}, {63'd0, vecs[i].eb1});
            chk($sformatf("v%0d_b2", i), {63'd0, busy_2}, {63'd0, vecs[i].eb2});
            chk($sformatf("v%0d_cnt", i), {58'd0, busy_count}, {58'd0, vecs[i].ecnt});
        end

        // Same-cycle write to r5 (holding 17) observed before the edge.
        reg_read_addr_1 = 5'd7;
        reg_read_addr_2 = 5'd5;
        reg_write       = 1'b1;
        reg_write_dest  = 5'd5;
        reg_write_data  = 64'd42;
        #1;
`ifdef REG_FILE_SB_BYPASS_EN
        chk("byp_rd2", reg_read_data_2, 64'd42);
`else
        chk("byp_rd2", reg_read_data_2, 64'd17);
`endif
        chk("byp_b2", {63'd0, busy_2}, 64'd0);
        chk("byp_rd1_other", reg_read_data_1, 64'd916);
        issue_valid = 1'b1;
        issue_dest  = 5'd5;
        #1;
`ifdef REG_FILE_SB_BYPASS_EN
        chk("byp_iss_b2", {63'd0, busy_2}, 64'd1);
`else
        chk("byp_iss_b2", {63'd0, busy_2}, 64'd0);
`endif
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        chk("byp_after_rd2", reg_read_data_2, 64'd42);
        chk("byp_after_b2", {63'd0, busy_2}, 64'd1);
        chk("byp_after_cnt", {58'd0, busy_count}, 64'd2);

        // Mark r1..r3 busy, then reset asynchronously mid-cycle.
        for (int r = 1; r <= 3; r++) begin
            issue_valid = 1'b1;
            issue_dest  = 5'(r);
            @(posedge clk);
            #1;
        end
        idle_inputs();
        reg_read_addr_1 = 5'd1;
        reg_read_addr_2 = 5'd7;
        #1;
        chk("pre_rst_cnt", {58'd0, busy_count}, 64'd5);
        chk("pre_rst_b1", {63'd0, busy_1}, 64'd1);
        reg_write      = 1'b1;
        reg_write_dest = 5'd1;
        reg_write_data = 64'd99;
        issue_valid    = 1'b1;
        issue_dest     = 5'd6;
        #1;
        reset = 1'b0;
        #1;
        chk("rst_rd1", reg_read_data_1, 64'd0);
        chk("rst_rd2", reg_read_data_2, 64'd0);
        chk("rst_b1", {63'd0, busy_1}, 64'd0);
        chk("rst_b2", {63'd0, busy_2}, 64'd0);
        chk("rst_cnt", {58'd0, busy_count}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        // First edge after release performs a normal write.
        reset          = 1'b1;
        reg_write      = 1'b1;
        reg_write_dest = 5'd2;
        reg_write_data = 64'h22;
        issue_valid    = 1'b0;
        @(posedge clk);
        #1;
        idle_inputs();
        reg_read_addr_1 = 5'd1;
        reg_read_addr_2 = 5'd2;
        #1;
        chk("rel_rd1", reg_read_data_1, 64'd0);
        chk("rel_b1", {63'd0, busy_1}, 64'd0);
        chk("rel_rd2", reg_read_data_2, 64'h22);
        chk("rel_cnt", {58'd0, busy_count}, 64'd0);
        reg_read_addr_1 = 5'd7;
        reg_read_addr_2 = 5'd6;
        #1;
        chk("rel_r7", reg_read_data_1, 64'd0);
        chk("rel_b6", {63'd0, busy_2}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
